kv_pingpong_buffer: RTL

- Double-buffered K/V row store that sits directly upstream of the attention stage.
- Accepts K and V rows, one pair per beat, from the projection stage over a valid/ready stream.
- Exposes a completed bank of M rows to attention through registered-read RAM ports: attention drives the addresses, this block returns the rows.
- While attention reads one bank, the projection stage fills the other, so back-to-back heads incur no load stall.

---
 rtl/npu_attn_pkg.sv | 18 +
 rtl/kv_bank_ram.sv | 32 +++
 rtl/kv_pingpong_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/npu_attn_pkg.sv
// Shared sizing and helpers for the attention front-end K/V buffering.
package npu_attn_pkg;

  localparam int unsigned ATTN_M = 166;
  localparam int unsigned ATTN_N = 44;
  localparam int unsigned ROW_W  = ATTN_N * 8;
  localparam int unsigned ADDR_W = $clog2(ATTN_M);

  typedef logic [ROW_W-1:0] row_t;

  // Flat RAM index for logical address {bank, row}. Each bank occupies M
  // consecutive words, so the RAM holds exactly 2*M rows with no holes.
  function automatic int unsigned ram_index(input logic bank, input int unsigned row,
                                            input int unsigned m);
    return bank ? (m + row) : row;
  endfunction

endpackage

// File: rtl/kv_bank_ram.sv
// Simple dual-port row RAM: one synchronous write port, one registered read port.
module kv_bank_ram #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: storage is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: one-cycle registered read.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/kv_pingpong_buffer.sv
// Double-buffered K/V row store feeding the attention stage. The projection
// stage fills one bank while attention reads the other through registered
// read ports.
module kv_pingpong_buffer
  import npu_attn_pkg::*;
#(
  parameter int unsigned M = ATTN_M,
  parameter int unsigned N = ATTN_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [N*8-1:0]       wr_k,
  input  logic [N*8-1:0]       wr_v,
  input  logic [$clog2(M)-1:0] K_ram_addr,
  output logic [N*8-1:0]       K_ram_data,
  input  logic [$clog2(M)-1:0] V_ram_addr,
  output logic [N*8-1:0]       V_ram_data,
  output logic                 rd_avail,
  input  logic                 rd_release,
  output logic                 release_err,
  output logic                 wr_bank,
  output logic                 rd_bank
);

  localparam int unsigned AW    = $clog2(M);
  localparam int unsigned RW    = N * 8;
  localparam int unsigned Depth = 2 * M;
  localparam int unsigned RamAw = $clog2(Depth);

  logic [AW-1:0]    wr_row_q, wr_row_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_cnt_q, full_cnt_d;
  logic             release_err_q, release_err_d;
  logic             k_zero_q, v_zero_q;

  logic             wr_accept;
  logic             bank_done;
  logic             release_ok;
  logic             k_in_range, v_in_range;
  logic [RamAw-1:0] wr_idx, k_rd_idx, v_rd_idx;
  logic [RW-1:0]    k_rdata, v_rdata;

  assign wr_ready   = (full_cnt_q != 2'd2);
  assign rd_avail   = (full_cnt_q != 2'd0);
  assign wr_accept  = wr_valid && wr_ready;
  assign bank_done  = wr_accept && (32'(wr_row_q) == M - 1);
  assign release_ok = rd_release && rd_avail;

  // Address mapping; out-of-range reads are steered to row 0 and masked later.
  always_comb begin
    k_in_range = (32'(K_ram_addr) < M);
    v_in_range = (32'(V_ram_addr) < M);
    wr_idx     = RamAw'(ram_index(wr_bank_q, 32'(wr_row_q), M));
    k_rd_idx   = RamAw'(ram_index(rd_bank_q, k_in_range ? 32'(K_ram_addr) : 32'd0, M));
    v_rd_idx   = RamAw'(ram_index(rd_bank_q, v_in_range ? 32'(V_ram_addr) : 32'd0, M));
  end

  // Next-state for the fill pointer, bank pointers and bank occupancy.
  always_comb begin
    wr_row_d      = wr_row_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    full_cnt_d    = full_cnt_q;
    release_err_d = release_err_q;

    if (wr_accept) begin
      if (bank_done) begin
        wr_row_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + AW'(1);
      end
    end

    if (release_ok) begin
      rd_bank_d = ~rd_bank_q;
    end else if (rd_release) begin
      release_err_d = 1'b1;
    end

    // Completion and release in the same cycle cancel out.
    unique case ({bank_done, release_ok})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_row_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_cnt_q    <= 2'd0;
      release_err_q <= 1'b0;
    end else begin
      wr_row_q      <= wr_row_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_cnt_q    <= full_cnt_d;
      release_err_q <= release_err_d;
    end
  end

  // Zero flags track the RAM read latency; held at 1 in reset so the
  // uninitialised RAM output is never visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_zero_q <= 1'b1;
      v_zero_q <= 1'b1;
    end else begin
      k_zero_q <= ~k_in_range;
      v_zero_q <= ~v_in_range;
    end
  end

  kv_bank_ram #(
    .DEPTH (Depth),
    .WIDTH (RW),
    .AW    (RamAw)
  ) u_k_ram (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_idx),
    .wdata_i (wr_k),
    .raddr_i (k_rd_idx),
    .rdata_o (k_rdata)
  );

  kv_bank_ram #(
    .DEPTH (Depth),
    .WIDTH (RW),
    .AW    (RamAw)
  ) u_v_ram (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_idx),
    .wdata_i (wr_v),
    .raddr_i (v_rd_idx),
    .rdata_o (v_rdata)
  );

  assign K_ram_data  = k_zero_q ? '0 : k_rdata;
  assign V_ram_data  = v_zero_q ? '0 : v_rdata;
  assign release_err = release_err_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;

endmodule
